// File: rtl/dvi_scan_out_pkg.sv
// Shared video definitions: default 640x480@60 timing, colour widths and the
// 3-bit to 24-bit colour expansion used by the frame buffer and scan-out.
package dvi_scan_out_pkg;

   localparam int COLOR_W = 3;
   localparam int CH_W    = 8;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef logic [COLOR_W-1:0] pix3_t;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   // Each stored bit saturates a whole channel: {R,G,B} -> {RRRRRRRR,...}.
   function automatic rgb_t expand_pix(input pix3_t p);
      rgb_t c;
      c.r = {CH_W{p[2]}};
      c.g = {CH_W{p[1]}};
      c.b = {CH_W{p[0]}};
      return c;
   endfunction

endpackage

// File: rtl/sync_pixel_fifo.sv
// Single-clock pixel FIFO. Writes to a full FIFO are dropped; the head entry
// is read combinationally from storage, so a write never bypasses to pop_data.
module sync_pixel_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 3,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // Fullness is judged on the registered count, so a pop in the same cycle
   // does not make room for a write that arrives while full.
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dvi_scan_out.sv
// DVI scan-out: raster timing counters, pixel FIFO drain and registered
// sync/DE/colour outputs, all advancing on the pixel clock enable.
module dvi_scan_out
   import dvi_scan_out_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_ce,
   input  logic [COLOR_W-1:0] fb_color_in,
   input  logic               fb_write_enable,
   output logic               fifo_full,
   output logic               frame_start,
   output logic               dvi_de,
   output logic               dvi_hsync,
   output logic               dvi_vsync,
   output logic [CH_W-1:0]    dvi_r,
   output logic [CH_W-1:0]    dvi_g,
   output logic [CH_W-1:0]    dvi_b,
   output logic               underflow,
   output logic               overflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic           h_last;
   logic           v_last;
   logic           active;
   logic           hsync_zone;
   logic           vsync_zone;
   logic           pop_en;
   pix3_t          fifo_head;
   logic           fifo_empty;
   logic           fifo_is_full;
   logic [CW-1:0]  fifo_count;
   rgb_t           head_rgb;

   sync_pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (COLOR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fb_write_enable),
      .push_data (fb_color_in),
      .pop       (pop_en),
      .pop_data  (fifo_head),
      .full      (fifo_is_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign fifo_full  = (fifo_count == FULL_CNT);

   assign h_last     = (h_cnt == H_LAST);
   assign v_last     = (v_cnt == V_LAST);
   assign active     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign hsync_zone = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   assign vsync_zone = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
   assign pop_en     = pix_ce && active && !fifo_empty;
   assign head_rgb   = expand_pix(fifo_head);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
         dvi_de      <= 1'b0;
         dvi_hsync   <= 1'b1;
         dvi_vsync   <= 1'b1;
         dvi_r       <= '0;
         dvi_g       <= '0;
         dvi_b       <= '0;
         underflow   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         // Fires on the pix_ce that steps from the last active line into front porch.
         frame_start <= pix_ce && h_last && (v_cnt == V_ACT_LAST);

         if (pix_ce) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;

            dvi_de    <= active;
            dvi_hsync <= !hsync_zone;
            dvi_vsync <= !vsync_zone;

            if (pop_en)
               {dvi_r, dvi_g, dvi_b} <= head_rgb;
            else
               {dvi_r, dvi_g, dvi_b} <= '0;

            if (active && fifo_empty) underflow <= 1'b1;
         end

         if (fb_write_enable && fifo_is_full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dvi_scan_out.sv
// Directed bench for dvi_scan_out: a behavioural raster/FIFO model predicts every
// output cycle; a second, shrunken-timing instance covers whole frames.
module tb_dvi_scan_out;

   localparam int DEPTH = 16;
   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 480, VF = 10, VS = 2,  VB = 33;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 2;
   localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
   localparam int S_FT = S_HT * S_VT;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_ce;
   logic [2:0] fb_color_in;
   logic       fb_write_enable;
   logic       fifo_full, frame_start, dvi_de, dvi_hsync, dvi_vsync;
   logic [7:0] dvi_r, dvi_g, dvi_b;
   logic       underflow, overflow;

   logic       rst_s, ce_s;
   logic       s_full, s_fs, s_de, s_hs, s_vs, s_uf, s_of;
   logic [7:0] s_r, s_g, s_b;

   int checks = 0;
   int errors = 0;

   // model state
   int         m_h, m_v;
   logic [2:0] q[$];
   logic       e_de, e_hs, e_vs, e_fs, e_uf, e_of;
   logic [23:0] e_rgb;

   always #5 clk = ~clk;

   dvi_scan_out dut (
      .clk (clk), .rst (rst), .pix_ce (pix_ce),
      .fb_color_in (fb_color_in), .fb_write_enable (fb_write_enable),
      .fifo_full (fifo_full), .frame_start (frame_start),
      .dvi_de (dvi_de), .dvi_hsync (dvi_hsync), .dvi_vsync (dvi_vsync),
      .dvi_r (dvi_r), .dvi_g (dvi_g), .dvi_b (dvi_b),
      .underflow (underflow), .overflow (overflow)
   );

   dvi_scan_out #(
      .FIFO_DEPTH (4),
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) dut_s (
      .clk (clk), .rst (rst_s), .pix_ce (ce_s),
      .fb_color_in (3'b000), .fb_write_enable (1'b0),
      .fifo_full (s_full), .frame_start (s_fs),
      .dvi_de (s_de), .dvi_hsync (s_hs), .dvi_vsync (s_vs),
      .dvi_r (s_r), .dvi_g (s_g), .dvi_b (s_b),
      .underflow (s_uf), .overflow (s_of)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input logic [2:0] c);
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

   task automatic check_outputs();
      check("de",          32'(dvi_de),      32'(e_de));
      check("hsync",       32'(dvi_hsync),   32'(e_hs));
      check("vsync",       32'(dvi_vsync),   32'(e_vs));
      check("rgb",         32'({dvi_r, dvi_g, dvi_b}), 32'(e_rgb));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("fifo_full",   32'(fifo_full),   32'(q.size() == DEPTH));
      check("underflow",   32'(underflow),   32'(e_uf));
      check("overflow",    32'(overflow),    32'(e_of));
      check("fifo_count",  32'(dut.u_fifo.count), 32'(q.size()));
   endtask

   // Drive one cycle at the falling edge, predict, then compare at the next falling edge.
   task automatic tick(input logic ce, input logic we, input logic [2:0] col);
      logic full_before;
      logic act;
      pix_ce          = ce;
      fb_write_enable = we;
      fb_color_in     = col;
      full_before     = (q.size() == DEPTH);
      e_fs            = ce && (m_h == HT - 1) && (m_v == VA - 1);
      if (ce) begin
         act  = (m_h < HA) && (m_v < VA);
         e_de = act;
         e_hs = !((m_h >= HA + HF) && (m_h <= HA + HF + HS - 1));
         e_vs = !((m_v >= VA + VF) && (m_v <= VA + VF + VS - 1));
         if (act && q.size() > 0) begin
            e_rgb = exp_rgb(q.pop_front());
         end else begin
            e_rgb = '0;
            if (act) e_uf = 1'b1;
         end
         if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
      end
      if (we) begin
         if (full_before) e_of = 1'b1;
         else q.push_back(col);
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      pix_ce          = 1'b1;
      fb_write_enable = 1'b1;
      fb_color_in     = 3'b111;
      @(posedge clk);
      @(negedge clk);
      rst             = 1'b0;
      pix_ce          = 1'b0;
      fb_write_enable = 1'b0;
      m_h = 0; m_v = 0;
      q.delete();
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
      e_fs = 1'b0; e_uf = 1'b0; e_of = 1'b0;
      check_outputs();
      check("h_cnt_reset", 32'(dut.h_cnt), 32'd0);
      check("v_cnt_reset", 32'(dut.v_cnt), 32'd0);
   endtask

   initial begin
      int c, line, h, fs_pulses, vs_low_cycles;
      rst = 1'b1; pix_ce = 1'b0; fb_write_enable = 1'b0; fb_color_in = '0;
      rst_s = 1'b1; ce_s = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // Fill to full with the counters frozen; the 17th write must be dropped.
      tick(1'b0, 1'b1, 3'b101);
      tick(1'b0, 1'b1, 3'b010);
      for (int i = 2; i < DEPTH; i++) tick(1'b0, 1'b1, 3'(i));
      tick(1'b0, 1'b1, 3'b111);
      check("head_after_drop", 32'(dut.u_fifo.pop_data), 32'h5);
      repeat (3) tick(1'b0, 1'b0, 3'b000);

      // Line 0: drain 16 entries, write alongside a pop at pixel 5, then starve.
      for (int p = 0; p < HT; p++) tick(1'b1, p == 5, 3'b011);

      // Line 1: write into an empty FIFO at pixel 10; it must appear one pixel later.
      for (int p = 0; p < 40; p++) tick(1'b1, p == 10, 3'b110);

      // Pixel clock enable toggling: outputs hold between enabled cycles.
      for (int p = 0; p < 60; p++) tick((p % 2) == 0, 1'b0, 3'b000);
      for (int p = 0; p < 230; p++) tick(1'b1, 1'b0, 3'b000);
      check("mid_line_h", 32'(dut.h_cnt), 32'd300);

      // Queue 8 entries mid-line, then reset: everything discarded.
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 3'($urandom_range(7)));
      do_reset();

      // Preload two pixels and show them at (0,0).
      tick(1'b0, 1'b1, 3'b101);
      tick(1'b0, 1'b1, 3'b010);
      repeat (4) tick(1'b1, 1'b0, 3'b000);

      // Shrunken-timing instance: two whole frames of vsync/DE/hsync/frame_start.
      rst_s = 1'b1; ce_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_s = 1'b0;
      check("s_reset_de", 32'(s_de), 32'd0);
      check("s_reset_vs", 32'(s_vs), 32'd1);
      check("s_reset_fs", 32'(s_fs), 32'd0);
      fs_pulses = 0;
      vs_low_cycles = 0;
      for (int k = 0; k < 2 * S_FT; k++) begin
         @(posedge clk);
         @(negedge clk);
         c    = k % S_FT;
         line = c / S_HT;
         h    = c % S_HT;
         check("s_vsync", 32'(s_vs),
               32'(!((line >= S_VA + S_VF) && (line <= S_VA + S_VF + S_VS - 1))));
         check("s_hsync", 32'(s_hs),
               32'(!((h >= S_HA + S_HF) && (h <= S_HA + S_HF + S_HS - 1))));
         check("s_de", 32'(s_de), 32'((h < S_HA) && (line < S_VA)));
         check("s_frame_start", 32'(s_fs), 32'(c == S_VA * S_HT - 1));
         if (s_fs) fs_pulses++;
         if (!s_vs) vs_low_cycles++;
      end
      check("s_fs_pulses", 32'(fs_pulses), 32'd2);
      check("s_vs_low_cycles", 32'(vs_low_cycles), 32'(2 * S_VS * S_HT));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dvi_scan_out.md
DVI_SCAN_OUT -- requirements
Module: dvi_scan_out

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two).
REQ-002 The block SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pix_ce  input  1  pixel clock enable; timing advances only when high.
REQ-007 fb_color_in  input  3  pixel colour from frame buffer, {R,G,B}.
REQ-008 fb_write_enable  input  1  push fb_color_in into the FIFO.
REQ-009 fifo_full  output  1  FIFO holds FIFO_DEPTH entries; the frame buffer must not write.
REQ-010 frame_start  output  1  one-cycle pulse at the first pixel of vertical front porch.
REQ-011 dvi_de  output  1  data enable, high in the active region.
REQ-012 dvi_hsync / dvi_vsync  output  1 each  syncs, active-low.
REQ-013 dvi_r / dvi_g / dvi_b  output  8 each  expanded colour.
REQ-014 underflow  output  1  sticky: an active pixel found the FIFO empty.
REQ-015 overflow  output  1  sticky: a write arrived while full.

Function
REQ-016 h_cnt SHALL run 0..H_total-1 (800) and v_cnt 0..V_total-1 (525); both advance only on pix_ce, h wraps to 0 and increments v, v wraps to 0 after 524.
REQ-017 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vsync low for v_cnt in [490, 491].
REQ-018 On a pix_ce cycle in the active region with FIFO non-empty, the head entry SHALL be popped.
REQ-019 All dvi_* outputs SHALL be registered, updated only on pix_ce cycles, and reflect the counter state of that same pix_ce cycle (one clk latency).
REQ-020 Colour expansion SHALL map each bit to 8'hFF when 1 and 8'h00 when 0; outside the active region colour SHALL be 0.
REQ-021 An active pixel with FIFO empty SHALL output black, perform no pop, and set underflow.
REQ-022 A write while the FIFO is full SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-023 A write and pop in the same cycle with the FIFO neither empty nor full SHALL leave the count unchanged and preserve order.
REQ-024 A write while the FIFO is empty SHALL NOT bypass to the output in the same cycle.
REQ-025 fifo_full SHALL be combinational from the registered count (count==FIFO_DEPTH).
REQ-026 frame_start SHALL pulse for exactly one clk when a pix_ce moves the counters to h_cnt=0, v_cnt=V_ACTIVE.
REQ-027 underflow and overflow SHALL clear only on rst.

Reset
REQ-028 On rst: h_cnt=0, v_cnt=0, FIFO emptied (pointers and count 0), fifo_full=0, dvi_de=0, dvi_hsync=1, dvi_vsync=1, colour=0, frame_start=0, underflow=0, overflow=0.
REQ-029 rst mid-frame SHALL discard FIFO contents and restart timing at (0,0) on the next cycle; rst overrides pix_ce and writes.

Structure
REQ-030 Timing defaults and colour-width constants SHALL live in the shared video package used by the frame buffer.
REQ-031 The FIFO SHALL be a sub-module, sync_pixel_fifo, with push/pop/full/empty/count; timing and output logic stay in dvi_scan_out.

Verification
REQ-032 Reset with pix_ce=1 -> first line: dvi_de high for 640 pix_ce cycles, hsync low for cycles 656..751, line length 800.
REQ-033 Write 16 entries with no pops -> fifo_full=1; 17th write dropped, overflow=1, head still the first entry.
REQ-034 Preload 3'b101, 3'b010 then enter active region -> outputs (FF,00,FF) then (00,FF,00), count 0.
REQ-035 Empty FIFO during active region -> colour 0, de=1, underflow=1 and stays 1 until rst.
REQ-036 Run 525 lines -> vsync low on lines 490 and 491 only; frame_start exactly one pulse per frame at (0,480).
REQ-037 Assert rst at (300,200) with 8 entries queued -> next cycle count=0, counters (0,0), all flags cleared.
